// File: rtl/neuron_train_seq.sv
// Training sequencer for a single sigmoid neuron: replays a sample buffer through
// FP/BP phase strobes for a programmed number of epochs, accumulating |dZ| as loss.
module neuron_train_seq #(
  parameter int N         = 2,
  parameter int BITS      = 16,
  parameter int DEPTH     = 16,
  parameter int FP_CYCLES = 8,
  parameter int BP_CYCLES = 8,
  parameter int LOSS_W    = 24,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_clear,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [N*BITS-1:0]   ld_x,
  input  logic [BITS-1:0]     ld_y,
  input  logic                start,
  input  logic [7:0]          epochs,
  output logic                FP,
  output logic                BP,
  output logic [N*BITS-1:0]   x,
  output logic [BITS-1:0]     y_true,
  input  logic [BITS-1:0]     y_in,
  input  logic [BITS-1:0]     dz_in,
  output logic [BITS-1:0]     y_last,
  output logic                busy,
  output logic                done,
  output logic [IW-1:0]       sample_idx,
  output logic [7:0]          epoch_cnt,
  output logic [LOSS_W-1:0]   loss,
  output logic                loss_valid
);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PMAX = (FP_CYCLES > BP_CYCLES) ? FP_CYCLES : BP_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0, S_FWD  = 3'd1, S_GAP1 = 3'd2, S_BWD = 3'd3,
                         S_GAP2 = 3'd4, S_NEXT = 3'd5, S_DONE = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        epoch_q, epoch_d, e_q, e_d;
  logic [LOSS_W-1:0] acc_q, acc_d, loss_q, loss_d;
  logic              lv_q, lv_d;
  logic [N*BITS-1:0] x_q, x_d;
  logic [BITS-1:0]   yt_q, yt_d, yl_q, yl_d;

  logic [N*BITS-1:0] mem_x [DEPTH];
  logic [BITS-1:0]   mem_y [DEPTH];

  logic              idle, wr_en, last_fp, last_bp, more_samples, more_epochs;
  logic [BITS-1:0]   dz_abs;
  logic [LOSS_W:0]   acc_sum;
  logic [IW-1:0]     idx_inc;

  assign idle     = (state_q == S_IDLE);
  assign ld_ready = idle && (count_q < CW'(DEPTH));
  assign wr_en    = ld_valid && ld_ready && !ld_clear;

  // Buffer contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[count_q[IW-1:0]] <= ld_x;
      mem_y[count_q[IW-1:0]] <= ld_y;
    end
  end

  // Most negative input has no positive twin; clamp it to the largest positive.
  always_comb begin
    dz_abs = dz_in;
    if (dz_in[BITS-1])
      dz_abs = (dz_in[BITS-2:0] == '0) ? {1'b0, {(BITS-1){1'b1}}} : -dz_in;
  end

  assign acc_sum      = {1'b0, acc_q} + (LOSS_W+1)'(dz_abs);
  assign last_fp      = (ph_q == PW'(FP_CYCLES - 1));
  assign last_bp      = (ph_q == PW'(BP_CYCLES - 1));
  assign idx_inc      = idx_q + IW'(1);
  assign more_samples = (CW'(idx_q) + CW'(1)) < count_q;
  assign more_epochs  = (9'(epoch_q) + 9'd1) < 9'(e_q);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    count_d = count_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    e_d     = e_q;
    acc_d   = acc_q;
    loss_d  = loss_q;
    lv_d    = 1'b0;
    x_d     = x_q;
    yt_d    = yt_q;
    yl_d    = yl_q;
    case (state_q)
      S_IDLE: begin
        if (ld_clear)   count_d = '0;
        else if (wr_en) count_d = count_q + CW'(1);
        if (start) begin
          if (count_q == '0 || epochs == 8'd0) begin
            state_d = S_DONE;
          end else begin
            e_d     = epochs;
            idx_d   = '0;
            epoch_d = 8'd0;
            acc_d   = '0;
            ph_d    = '0;
            x_d     = mem_x[0];
            yt_d    = mem_y[0];
            state_d = S_FWD;
          end
        end
      end
      S_FWD: begin
        if (last_fp) begin
          ph_d    = '0;
          yl_d    = y_in;
          state_d = S_GAP1;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_GAP1: state_d = S_BWD;
      S_BWD: begin
        if (last_bp) begin
          ph_d    = '0;
          acc_d   = acc_sum[LOSS_W] ? '1 : acc_sum[LOSS_W-1:0];
          state_d = S_GAP2;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_GAP2: state_d = S_NEXT;
      S_NEXT: begin
        if (more_samples) begin
          idx_d   = idx_inc;
          x_d     = mem_x[idx_inc];
          yt_d    = mem_y[idx_inc];
          state_d = S_FWD;
        end else begin
          loss_d  = acc_q;
          lv_d    = 1'b1;
          acc_d   = '0;
          epoch_d = epoch_q + 8'd1;
          idx_d   = '0;
          x_d     = mem_x[0];
          yt_d    = mem_y[0];
          state_d = more_epochs ? S_FWD : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      count_q <= '0;
      idx_q   <= '0;
      epoch_q <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      loss_q  <= '0;
      lv_q    <= 1'b0;
      x_q     <= '0;
      yt_q    <= '0;
      yl_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      loss_q  <= loss_d;
      lv_q    <= lv_d;
      x_q     <= x_d;
      yt_q    <= yt_d;
      yl_q    <= yl_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign FP         = (state_q == S_FWD);
  assign BP         = (state_q == S_BWD);
  assign busy       = !idle;
  assign done       = (state_q == S_DONE);
  assign x          = x_q;
  assign y_true     = yt_q;
  assign y_last     = yl_q;
  assign sample_idx = idx_q;
  assign epoch_cnt  = epoch_q;
  assign loss       = loss_q;
  assign loss_valid = lv_q;

endmodule

// File: tb/tb_neuron_train_seq.sv
// Bench for neuron_train_seq: stub neuron feeds per-sample dZ/y, expected epoch
// losses go into a scoreboard and are compared against what the DUT reports.
module tb_neuron_train_seq;
  localparam int N = 2, BITS = 16, DEPTH = 4, FPC = 8, BPC = 8, IW = 2;

  logic clk = 1'b0;
  logic rst, ld_clear, ld_valid, start;
  logic [N*BITS-1:0] ld_x;
  logic [BITS-1:0] ld_y, y_in, dz_in;
  logic [7:0] epochs;

  logic ld_ready, FP, BP, busy, done, loss_valid;
  logic [N*BITS-1:0] x;
  logic [BITS-1:0] y_true, y_last;
  logic [IW-1:0] sample_idx;
  logic [7:0] epoch_cnt;
  logic [23:0] loss;

  logic s_ld_ready, s_FP, s_BP, s_busy, s_done, s_loss_valid;
  logic [N*BITS-1:0] s_x;
  logic [BITS-1:0] s_y_true, s_y_last;
  logic [IW-1:0] s_sample_idx;
  logic [7:0] s_epoch_cnt;
  logic [15:0] s_loss;

  always #5 clk = ~clk;

  neuron_train_seq #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .FP_CYCLES(FPC), .BP_CYCLES(BPC), .LOSS_W(24)) u_dut (
    .clk(clk), .rst(rst), .ld_clear(ld_clear), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_x(ld_x), .ld_y(ld_y), .start(start), .epochs(epochs), .FP(FP), .BP(BP),
    .x(x), .y_true(y_true), .y_in(y_in), .dz_in(dz_in), .y_last(y_last), .busy(busy),
    .done(done), .sample_idx(sample_idx), .epoch_cnt(epoch_cnt), .loss(loss), .loss_valid(loss_valid));

  // Narrow-accumulator copy in lockstep, to exercise saturation.
  neuron_train_seq #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .FP_CYCLES(FPC), .BP_CYCLES(BPC), .LOSS_W(16)) u_sat (
    .clk(clk), .rst(rst), .ld_clear(ld_clear), .ld_valid(ld_valid), .ld_ready(s_ld_ready),
    .ld_x(ld_x), .ld_y(ld_y), .start(start), .epochs(epochs), .FP(s_FP), .BP(s_BP),
    .x(s_x), .y_true(s_y_true), .y_in(y_in), .dz_in(dz_in), .y_last(s_y_last), .busy(s_busy),
    .done(s_done), .sample_idx(s_sample_idx), .epoch_cnt(s_epoch_cnt), .loss(s_loss), .loss_valid(s_loss_valid));

  logic [N*BITS-1:0] xs [5];
  logic [BITS-1:0]   ys [5];
  logic [BITS-1:0]   y_tab [4];
  logic [BITS-1:0]   dz_tab [4];

  logic [23:0] exp_loss [$], obs_loss [$];
  logic [15:0] exp_sat [$], obs_sat [$];
  logic [N*BITS-1:0] obs_x [$];
  logic [BITS-1:0] obs_yt [$];
  logic [23:0] last_exp;

  int errors = 0, checks = 0;
  int done_cyc, busy_cyc, fp_cyc, bp_cyc, overlap, lock_diff;
  bit to;
  bit fp_hist [64];
  bit bp_hist [64];

  function automatic int abs_m(input logic [15:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic push_expected(input int n, input int ep);
    int sum;
    sum = 0;
    for (int i = 0; i < n; i++) sum += abs_m(dz_tab[i]);
    last_exp = 24'((sum > 24'hFFFFFF) ? 24'hFFFFFF : sum);
    for (int e = 0; e < ep; e++) begin
      exp_loss.push_back(last_exp);
      exp_sat.push_back(16'((sum > 65535) ? 65535 : sum));
    end
  endtask

  task automatic clear_buf();
    @(negedge clk); ld_clear = 1'b1;
    @(negedge clk); ld_clear = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ld_valid = 1'b1; ld_x = xs[i]; ld_y = ys[i];
    end
    @(negedge clk); ld_valid = 1'b0;
  endtask

  // Starts a run and plays the neuron until done or the cycle budget expires.
  task automatic run(input int ep, input int n, input int maxc);
    int sid;
    bit fpp;
    sid = 0; fpp = 1'b0; to = 1'b1;
    done_cyc = 0; busy_cyc = 0; fp_cyc = 0; bp_cyc = 0; overlap = 0; lock_diff = 0;
    obs_loss.delete(); obs_sat.delete(); obs_x.delete(); obs_yt.delete();
    for (int c = 0; c < 64; c++) begin fp_hist[c] = 1'b0; bp_hist[c] = 1'b0; end
    @(negedge clk); epochs = 8'(ep); start = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk); start = 1'b0;
      if (FP && !fpp && n > 0) begin
        obs_x.push_back(x); obs_yt.push_back(y_true);
        y_in = y_tab[sid]; dz_in = dz_tab[sid];
        sid = (sid + 1) % n;
      end
      fpp = FP;
      if (c < 64) begin fp_hist[c] = FP; bp_hist[c] = BP; end
      if (FP) fp_cyc++;
      if (BP) bp_cyc++;
      if (busy) busy_cyc++;
      if (FP && BP) overlap++;
      if ({s_FP, s_BP, s_busy, s_done, s_ld_ready, s_x, s_y_true, s_y_last, s_sample_idx, s_epoch_cnt} !==
          {FP, BP, busy, done, ld_ready, x, y_true, y_last, sample_idx, epoch_cnt}) lock_diff++;
      if (loss_valid) obs_loss.push_back(loss);
      if (s_loss_valid) obs_sat.push_back(s_loss);
      if (done) begin done_cyc = c; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_clear = 0; ld_valid = 0; start = 0; epochs = 0;
    ld_x = '0; ld_y = '0; y_in = '0; dz_in = '0;
    repeat (2) @(negedge clk);
    checks++; if ({FP, BP, busy, done, loss_valid} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 00000", {FP, BP, busy, done, loss_valid}); end
    checks++; if (loss !== 24'h0) begin errors++; $display("FAIL reset_loss: got %0h expected 0", loss); end
    checks++; if ({epoch_cnt, sample_idx} !== 10'h0) begin errors++; $display("FAIL reset_counters: got %0h expected 0", {epoch_cnt, sample_idx}); end
    checks++; if ({x, y_true, y_last} !== 64'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", {x, y_true, y_last}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
  endtask

  task automatic test_load();
    clear_buf();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ld_valid = 1'b1; ld_x = xs[i]; ld_y = ys[i];
      checks++; if (ld_ready !== (i < 4)) begin errors++; $display("FAIL load_ready[%0d]: got %b expected %b", i, ld_ready, (i < 4)); end
    end
    @(negedge clk); ld_valid = 1'b0;
    dz_tab[0] = 16'hFF80; dz_tab[1] = 16'h0040; dz_tab[2] = 16'h0100; dz_tab[3] = 16'hFFFF;
    push_expected(4, 1);
    run(1, 4, 200);
    checks++; if (to) begin errors++; $display("FAIL load_timeout: got no done expected done"); end
    checks++; if (obs_x.size() != 4) begin errors++; $display("FAIL load_samples: got %0d expected 4", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < 4; i++) begin
      checks++; if ({obs_x[i], obs_yt[i]} !== {xs[i], ys[i]}) begin errors++; $display("FAIL load_sample[%0d]: got %0h expected %0h", i, {obs_x[i], obs_yt[i]}, {xs[i], ys[i]}); end
    end
    checks++; if (obs_loss.size() != exp_loss.size()) begin errors++; $display("FAIL load_loss_count: got %0d expected %0d", obs_loss.size(), exp_loss.size()); end
    while (obs_loss.size() > 0 && exp_loss.size() > 0) begin
      logic [23:0] o, e;
      o = obs_loss.pop_front(); e = exp_loss.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL load_loss: got %0h expected %0h", o, e); end
    end
    checks++; if (y_last !== y_tab[3]) begin errors++; $display("FAIL load_y_last: got %0h expected %0h", y_last, y_tab[3]); end
    exp_loss.delete(); exp_sat.delete();
  endtask

  task automatic test_timing();
    bit efp, ebp;
    int p;
    clear_buf(); load(2);
    dz_tab[0] = 16'hFF80; dz_tab[1] = 16'h0040;
    push_expected(2, 1);
    run(1, 2, 100);
    checks++; if (to || done_cyc != 39) begin errors++; $display("FAIL timing_done: got cycle %0d expected 39", done_cyc); end
    for (int c = 1; c <= 38; c++) begin
      p = (c - 1) % 19;
      efp = (p < 8); ebp = (p >= 9 && p < 17);
      checks++; if ({fp_hist[c], bp_hist[c]} !== {efp, ebp}) begin errors++; $display("FAIL timing_cycle[%0d]: got FP/BP %b%b expected %b%b", c, fp_hist[c], bp_hist[c], efp, ebp); end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL timing_overlap: got %0d expected 0", overlap); end
    checks++; if (obs_loss.size() != 1 || exp_loss.size() != 1) begin errors++; $display("FAIL timing_loss_count: got %0d expected 1", obs_loss.size()); end
    while (obs_loss.size() > 0 && exp_loss.size() > 0) begin
      logic [23:0] o, e;
      o = obs_loss.pop_front(); e = exp_loss.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL timing_loss: got %0h expected %0h", o, e); end
    end
    checks++; if (loss !== 24'h0000C0) begin errors++; $display("FAIL timing_loss_reg: got %0h expected c0", loss); end
    checks++; if (epoch_cnt !== 8'd1) begin errors++; $display("FAIL timing_epoch_cnt: got %0d expected 1", epoch_cnt); end
    checks++; if (y_last !== y_tab[1]) begin errors++; $display("FAIL timing_y_last: got %0h expected %0h", y_last, y_tab[1]); end
    exp_loss.delete(); exp_sat.delete();
  endtask

  task automatic test_abs_min();
    clear_buf(); load(1);
    dz_tab[0] = 16'h8000;
    push_expected(1, 4);
    run(4, 1, 200);
    checks++; if (to || done_cyc != 4 * 19 + 1) begin errors++; $display("FAIL absmin_done: got cycle %0d expected %0d", done_cyc, 4 * 19 + 1); end
    checks++; if (fp_cyc != 4 * FPC || bp_cyc != 4 * BPC) begin errors++; $display("FAIL absmin_phases: got %0d/%0d expected %0d/%0d", fp_cyc, bp_cyc, 4 * FPC, 4 * BPC); end
    checks++; if (obs_loss.size() != 4 || obs_sat.size() != 4) begin errors++; $display("FAIL absmin_loss_count: got %0d/%0d expected 4/4", obs_loss.size(), obs_sat.size()); end
    while (obs_loss.size() > 0 && exp_loss.size() > 0) begin
      logic [23:0] o, e;
      o = obs_loss.pop_front(); e = exp_loss.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL absmin_loss: got %0h expected %0h", o, e); end
    end
    while (obs_sat.size() > 0 && exp_sat.size() > 0) begin
      logic [15:0] o, e;
      o = obs_sat.pop_front(); e = exp_sat.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL absmin_loss16: got %0h expected %0h", o, e); end
    end
    checks++; if (epoch_cnt !== 8'd4) begin errors++; $display("FAIL absmin_epoch_cnt: got %0d expected 4", epoch_cnt); end
    exp_loss.delete(); exp_sat.delete();
  endtask

  task automatic test_saturate();
    clear_buf(); load(4);
    for (int i = 0; i < 4; i++) dz_tab[i] = 16'h8000;
    push_expected(4, 1);
    run(1, 4, 200);
    checks++; if (to) begin errors++; $display("FAIL sat_timeout: got no done expected done"); end
    checks++; if (lock_diff != 0) begin errors++; $display("FAIL sat_lockstep: got %0d differing cycles expected 0", lock_diff); end
    checks++; if (obs_loss.size() != 1 || obs_sat.size() != 1) begin errors++; $display("FAIL sat_loss_count: got %0d/%0d expected 1/1", obs_loss.size(), obs_sat.size()); end
    while (obs_loss.size() > 0 && exp_loss.size() > 0) begin
      logic [23:0] o, e;
      o = obs_loss.pop_front(); e = exp_loss.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL sat_loss24: got %0h expected %0h", o, e); end
    end
    while (obs_sat.size() > 0 && exp_sat.size() > 0) begin
      logic [15:0] o, e;
      o = obs_sat.pop_front(); e = exp_sat.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL sat_loss16: got %0h expected %0h", o, e); end
    end
    exp_loss.delete(); exp_sat.delete();
  endtask

  task automatic test_zero_start();
    run(0, 4, 10);
    checks++; if (to || done_cyc != 1) begin errors++; $display("FAIL zero_ep_done: got cycle %0d expected 1", done_cyc); end
    checks++; if (fp_cyc + bp_cyc != 0 || busy_cyc > 1) begin errors++; $display("FAIL zero_ep_activity: got fp+bp %0d busy %0d expected 0 and <=1", fp_cyc + bp_cyc, busy_cyc); end
    checks++; if (loss !== last_exp || obs_loss.size() != 0) begin errors++; $display("FAIL zero_ep_loss: got %0h expected %0h unchanged", loss, last_exp); end
    clear_buf();
    run(3, 0, 10);
    checks++; if (to || done_cyc != 1) begin errors++; $display("FAIL zero_cnt_done: got cycle %0d expected 1", done_cyc); end
    checks++; if (fp_cyc + bp_cyc != 0 || busy_cyc > 1) begin errors++; $display("FAIL zero_cnt_activity: got fp+bp %0d busy %0d expected 0 and <=1", fp_cyc + bp_cyc, busy_cyc); end
  endtask

  task automatic test_reset_mid_run();
    int rises;
    bit bpp, hit;
    clear_buf(); load(2);
    @(negedge clk); epochs = 8'd2; start = 1'b1;
    rises = 0; bpp = 1'b0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk); start = 1'b0;
      if (BP && !bpp) rises++;
      bpp = BP;
      if (rises == 2 && BP) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_bwd: got no second BWD expected one"); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({FP, BP, busy, done, loss_valid} !== 5'b0) begin errors++; $display("FAIL rstmid_outputs: got %b expected 00000", {FP, BP, busy, done, loss_valid}); end
    @(negedge clk); rst = 1'b0;
    run(1, 0, 10);
    checks++; if (to || done_cyc != 1 || fp_cyc != 0) begin errors++; $display("FAIL rstmid_count_cleared: got done %0d fp %0d expected 1/0", done_cyc, fp_cyc); end
    load(2);
    dz_tab[0] = 16'h0100; dz_tab[1] = 16'hFE00;
    push_expected(2, 2);
    run(2, 2, 200);
    checks++; if (to || obs_x.size() != 4) begin errors++; $display("FAIL rstmid_rerun: got %0d samples expected 4", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < 4; i++) begin
      checks++; if (obs_x[i] !== xs[i % 2]) begin errors++; $display("FAIL rstmid_order[%0d]: got %0h expected %0h", i, obs_x[i], xs[i % 2]); end
    end
    checks++; if (obs_loss.size() != 2) begin errors++; $display("FAIL rstmid_loss_count: got %0d expected 2", obs_loss.size()); end
    while (obs_loss.size() > 0 && exp_loss.size() > 0) begin
      logic [23:0] o, e;
      o = obs_loss.pop_front(); e = exp_loss.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rstmid_loss: got %0h expected %0h", o, e); end
    end
    checks++; if (epoch_cnt !== 8'd2) begin errors++; $display("FAIL rstmid_epoch_cnt: got %0d expected 2", epoch_cnt); end
    exp_loss.delete(); exp_sat.delete();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      xs[i] = {16'(i * 3 + 1), 16'(i * 7 + 2)};
      ys[i] = 16'(i * 256 + 16);
    end
    y_tab[0] = 16'h0180; y_tab[1] = 16'h0040; y_tab[2] = 16'hFF00; y_tab[3] = 16'h0123;
    for (int i = 0; i < 4; i++) dz_tab[i] = '0;
    last_exp = '0;
    test_reset();
    test_load();
    test_timing();
    test_abs_min();
    test_saturate();
    test_zero_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_train_seq.md
Name: neuron_train_seq

Overview:
- Upstream sequencer for the single sigmoid neuron.
- Holds a buffer of training samples, each being N features plus a target. For every sample it presents x and y_true, then drives the neuron's FP and BP phase strobes with fixed phase lengths.
- Captures the neuron's y and dZ results and accumulates a per-epoch saturating sum of |dZ| as the loss.
- Runs a programmable number of epochs, then raises done.

Parameters:
- N, 2, features per sample; must match the neuron's N.
- BITS, 16, word width; Q8.8 two's complement.
- DEPTH, 16, sample buffer entries (power of 2).
- FP_CYCLES, 8, cycles FP is held high per sample (≥1).
- BP_CYCLES, 8, cycles BP is held high per sample (≥1).
- LOSS_W, 24, loss accumulator width (> BITS).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_clear  in  1  in IDLE: empties the sample buffer (count←0).
- ld_valid  in  1  sample write request.
- ld_ready  out  1  buffer can accept a sample.
- ld_x  in  N*BITS  sample features; feature i is at [i*BITS +: BITS].
- ld_y  in  BITS  sample target.
- start  in  1  begin training (sampled in IDLE only).
- epochs  in  8  epoch count, latched on start.
- FP  out  1  forward-phase strobe to the neuron.
- BP  out  1  backward-phase strobe to the neuron.
- x  out  N*BITS  current sample features.
- y_true  out  BITS  current sample target.
- y_in  in  BITS  neuron output y.
- dz_in  in  BITS  neuron output dZ.
- y_last  out  BITS  last captured y.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at training completion.
- sample_idx  out  log2(DEPTH)  index of the current sample.
- epoch_cnt  out  8  completed epochs in the current run.
- loss  out  LOSS_W  registered epoch loss.
- loss_valid  out  1  one-cycle pulse when loss updates.

Behaviour:
- Reset: all outputs 0, count=0, state IDLE. Buffer contents are don't-care.
- Load (IDLE only):
  - ld_ready = (state==IDLE) && (count<DEPTH).
  - On ld_valid&&ld_ready: write mem[count]; count++.
  - ld_clear has priority over a simultaneous write; the write is dropped.
  - ld_valid while not ready: ignored, no error.
- Start:
  - start in IDLE with count>0: latch epochs to E; sample_idx=0, epoch_cnt=0, acc=0; go to FWD.
  - start with count==0 or epochs==0: done pulses next cycle, no FP/BP activity, loss unchanged.
  - start while busy: ignored.
- States and transitions:
  - IDLE → FWD on accepted start.
  - FWD: FP=1 for exactly FP_CYCLES cycles. On the edge ending the last FWD cycle, y_last←y_in. Then GAP1.
  - GAP1: 1 cycle, FP=BP=0. The neuron is edge-triggered on FP/BP, so a low cycle is mandatory between phases. Then BWD.
  - BWD: BP=1 for exactly BP_CYCLES cycles. On the edge ending the last BWD cycle, acc←sat(acc+|dz_in|). Then GAP2.
  - GAP2: 1 cycle, FP=BP=0. Then NEXT.
  - NEXT, if sample_idx<count-1: sample_idx++, go to FWD.
  - NEXT, otherwise: loss←acc, loss_valid pulses, acc←0, epoch_cnt++, sample_idx←0. Go to FWD if epoch_cnt+1<E, else DONE.
  - DONE: done=1 for 1 cycle → IDLE.
- Per-sample period is FP_CYCLES+BP_CYCLES+3 cycles.
- x and y_true are registered from mem[sample_idx]. They are stable through FWD, GAP1, BWD and GAP2, and update in NEXT.
- |dz_in|:
  - Two's-complement negate when the sign bit is set.
  - 16'h8000 maps to 16'h7FFF.
  - The result is zero-extended to LOSS_W.
- Accumulation saturates at 2^LOSS_W−1 and does not wrap.
- FP and BP are never high in the same cycle.
- Reset mid-run: immediate return to IDLE, with FP, BP, busy, done and loss_valid at 0. count is also cleared.

Test Plan:
- Load 3 samples with ld_valid held; ld_ready stays 1; count=3. With DEPTH=4, a 5th write attempt sees ld_ready=0 after the 4th write and is not stored.
- count=2, epochs=1, FP_CYCLES=BP_CYCLES=8 → FP high cycles 1–8, low cycle 9, BP high 10–17, gap 18, NEXT 19, second sample FWD from cycle 20. done pulses 38 cycles after start (2×19 cycles), plus the DONE state.
- Stub neuron drives dz_in=16'hFF80 (−0.5) and then 16'h0040 (+0.25) → loss=24'h0000C0 with loss_valid; epoch_cnt=1.
- dz_in=16'h8000 for 1 sample, LOSS_W=16 → |dz|=16'h7FFF. Repeated across 4 epochs, loss is 16'h7FFF each epoch; the accumulator resets per epoch.
- start with epochs=0 → done next cycle, FP/BP never assert, busy pulses ≤1 cycle. start with count=0 → same response.
- Assert rst during BWD of sample 1 → BP=0 within the same cycle (asynchronous), busy=0, count=0. Reload and restart → runs normally.
